// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int CNT_W = 4;
    localparam int BE_W  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// mem[] is left visible so benches can preload it hierarchically.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [AW-1:0]   idx,
  input  logic [BE_W-1:0] be,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data req/gnt/rvalid interface: grant wait-states,
// programmable response latency, single outstanding request.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          GNT_WAIT    = 0,
    parameter int          RVALID_LAT  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            data_req_i,
    output logic            data_gnt_o,
    input  logic            data_we_i,
    input  logic [BE_W-1:0] data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [31:0]     data_wdata_i,
    output logic            data_rvalid_o,
    output logic [31:0]     data_rdata_o,
    output logic            data_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    logic             rd_ok_q, rd_ok_d;

    logic [31:0]      offset;
    logic             in_range;
    logic [AW-1:0]    idx;
    logic             rvalid_fire;
    logic             slot_free;
    logic             wait_done;
    logic             accept;
    logic [31:0]      arr_rdata;
    logic             unused_addr_bits;

    // Wrap-around subtraction: addresses below BASE_ADDR land far out of range.
    assign offset           = data_addr_i - BASE_ADDR;
    assign in_range         = (offset >> (AW + 2)) == 32'd0;
    assign idx              = offset[AW+1:2];
    assign unused_addr_bits = ^offset[1:0];

    assign rvalid_fire = (state_q == ST_RESP) && (lat_q == '0);
    assign slot_free   = (state_q == ST_IDLE) || rvalid_fire;
    assign wait_done   = (wait_q == CNT_W'(GNT_WAIT));
    // Gated by reset so nothing is granted while rst_ni is held low.
    assign data_gnt_o  = rst_ni & data_req_i & wait_done & slot_free;
    assign accept      = data_gnt_o;

    assign data_rvalid_o = rvalid_fire;
    assign data_err_o    = rvalid_fire & err_q;
    assign data_rdata_o  = (rvalid_fire && rd_ok_q) ? arr_rdata : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_en  (accept & data_we_i & in_range),
        .rd_en  (accept & ~data_we_i & in_range),
        .idx    (idx),
        .be     (data_be_i),
        .wdata  (data_wdata_i),
        .rdata  (arr_rdata)
    );

    // Next-state: wait counter saturates at GNT_WAIT, latency counts down to rvalid.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        wait_d  = wait_q;
        err_d   = err_q;
        rd_ok_d = rd_ok_q;

        if (!data_req_i || accept) begin
            wait_d = '0;
        end else if (!wait_done) begin
            wait_d = wait_q + 1'b1;
        end

        case (state_q)
            ST_RESP: begin
                if (rvalid_fire) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: ;
        endcase

        // A new accept overrides the retire in the same cycle.
        if (accept) begin
            state_d = ST_RESP;
            lat_d   = CNT_W'(RVALID_LAT - 1);
            err_d   = ~in_range;
            rd_ok_d = ~data_we_i & in_range;
        end
    end

    // State, counters and response attributes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

`ifndef SYNTHESIS
    // A requester must hold req until it is granted.
    a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_req_i && !data_gnt_o) |=> data_req_i);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances cover the
// zero-wait, wait-state/latency and offset-base/small-depth configurations.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n  [3];
    logic        req    [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_en  = 1'b0;
    logic [31:0] model [16];

    dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RVALID_LAT(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

    dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .GNT_WAIT(3), .RVALID_LAT(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

    dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .GNT_WAIT(0), .RVALID_LAT(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_we_i(we[2]), .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{rdata: 32'h0, err: 1'b0, due: 0};
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic idle(input int k);
        req[k]   = 1'b0;
        we[k]    = 1'b0;
        be[k]    = 4'h0;
        addr[k]  = 32'h0;
        wdata[k] = 32'h0;
    endtask

    // Call #1 after a posedge; returns #1 after the accept edge with req still high.
    task automatic do_req(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                          output int gc);
        exp_t e;
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        gc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[k]) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) begin
            check("gnt_timeout", 32'd0, 32'd1);
        end else begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.due   = gc + lat_of(k);
            push_exp(k, e);
        end
        @(posedge clk);
        #1;
    endtask

    // In-range transfer on instance 0 with expected data taken from the word model.
    task automatic txn0(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output int gc);
        logic [31:0] exp_rd;
        int          wi;
        wi = int'(a[5:2]);
        exp_rd = 32'h0;
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) model[wi][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            exp_rd = model[wi];
        end
        do_req(0, w, b, a, d, exp_rd, 1'b0, gc);
    endtask

    // Response monitor: every rvalid is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (rvalid[k] === 1'b1) begin
                    pop_exp(k, ok, e);
                    if (!ok) begin
                        check("spurious_rvalid", 32'd1, 32'd0);
                    end else begin
                        check("rsp_cycle", 32'(cyc), 32'(e.due));
                        check("rsp_rdata", rdata[k], e.rdata);
                        check("rsp_err", {31'b0, err[k]}, {31'b0, e.err});
                    end
                end else begin
                    check("idle_outputs_zero", {31'b0, (rdata[k] !== 32'h0) || (err[k] !== 1'b0)}, 32'd0);
                end
            end
        end
    end

    initial begin : main
        int gc, gc_prev, c0, gw;
        logic        rw;
        logic [3:0]  rb;
        logic [31:0] ra;

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            idle(k);
        end

        // Reset: a held request must not be granted.
        req[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("gnt_in_reset", {31'b0, gnt[0]}, 32'd0);
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_gnt", {31'b0, gnt[k]}, 32'd0);
            check("reset_rvalid", {31'b0, rvalid[k]}, 32'd0);
            check("reset_rdata_err", rdata[k] | {31'b0, err[k]}, 32'd0);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Fill the modelled words back to back.
        for (int i = 0; i < 16; i++) txn0(1'b1, 4'hF, 32'(i * 4), $urandom, gc);

        // Write then read the same word on consecutive cycles.
        txn0(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, gc_prev);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, gc);
        check("t1_b2b_gnt", 32'(gc - gc_prev), 32'd1);

        // Partial byte-lane write.
        txn0(1'b1, 4'hF, 32'h20, 32'h1122_3344, gc);
        txn0(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, gc);
        do_req(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB_33DD, 1'b0, gc);
        model[8] = 32'h11BB_33DD;

        // be=0 write is a no-op.
        txn0(1'b1, 4'h0, 32'h24, 32'hFFFF_FFFF, gc);
        txn0(1'b0, 4'hF, 32'h24, 32'h0, gc);

        // Out-of-range accesses: error response, memory untouched.
        do_req(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0, 32'h0, 1'b1, gc);
        do_req(0, 1'b1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0, 1'b1, gc);
        do_req(0, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 1'b1, gc);
        txn0(1'b0, 4'hF, 32'h0, 32'h0, gc);
        txn0(1'b0, 4'hF, 32'h3C, 32'h0, gc);

        // Random back-to-back stream: one accept per cycle.
        gc_prev = 0;
        for (int i = 0; i < 16; i++) begin
            rw = 1'($urandom_range(0, 1));
            rb = 4'($urandom);
            ra = {26'h0, 4'($urandom), 2'b00};
            txn0(rw, rb, ra, $urandom, gc);
            if (i > 0) check("t6_gnt_seq", 32'(gc - gc_prev), 32'd1);
            gc_prev = gc;
        end
        idle(0);

        // Wait-states and latency: gnt at cycle 3, rvalid at 7, next gnt at 7.
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h8; wdata[1] = 32'hCAFE_F00D;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gw = (i == 3 || i == 7) ? 1 : 0;
            check("t3_gnt", {31'b0, gnt[1]}, 32'(gw));
            if (i == 3) push_exp(1, '{rdata: 32'h0, err: 1'b0, due: c0 + 7});
            if (i == 7) push_exp(1, '{rdata: 32'hCAFE_F00D, err: 1'b0, due: c0 + 11});
            if (i == 3) begin
                @(posedge clk);
                #1;
                we[1] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        idle(1);

        // Reset while a read is pending drops its response.
        do_req(2, 1'b1, 4'hF, 32'h0000_1004, 32'h0BAD_C0DE, 32'h0, 1'b0, gc);
        idle(2);
        repeat (4) @(posedge clk);
        #1;
        req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h0000_1004;
        gc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt[2]) begin
                gc = cyc;
                break;
            end
        end
        check("t5_read_gnt", {31'b0, gc >= 0}, 32'd1);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("t5_gnt_in_reset", {31'b0, gnt[2]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        idle(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_rvalid", {31'b0, rvalid[2]}, 32'd0);
        end
        @(posedge clk);
        #1;
        do_req(2, 1'b0, 4'hF, 32'h0000_1004, 32'h0, 32'h0BAD_C0DE, 1'b0, gc);

        // Base-offset range edges.
        do_req(2, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0, 32'h0, 1'b1, gc);
        do_req(2, 1'b0, 4'hF, 32'h0000_1100, 32'h0, 32'h0, 1'b1, gc);
        do_req(2, 1'b1, 4'hF, 32'h0000_10FC, 32'h1357_9BDF, 32'h0, 1'b0, gc);
        do_req(2, 1'b0, 4'hF, 32'h0000_10FC, 32'h0, 32'h1357_9BDF, 1'b0, gc);
        idle(2);

        for (int i = 0; i < 50; i++) begin
            if (q0.size() + q1.size() + q2.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
